// File: rtl/tts_host_msg_dec_if.sv
// tts_host_msg_dec_if: host message, RCB RAM strobe and response bundle for the host-message decoder.
interface tts_host_msg_dec_if;
    logic         host_vld;
    logic         host_rdy;
    logic [255:0] host_msg;
    logic [3:0]   ram_sel;
    logic         ram_we;
    logic         ram_re;
    logic [15:0]  ram_addr;
    logic [23:0]  ram_be;
    logic [191:0] ram_wdata;
    logic [191:0] ram_rdata;
    logic         rsp_vld;
    logic         rsp_rdy;
    logic [255:0] rsp_data;
    modport master (
        output host_vld, host_msg, ram_rdata, rsp_rdy,
        input  host_rdy, ram_sel, ram_we, ram_re, ram_addr, ram_be, ram_wdata, rsp_vld, rsp_data
    );
    modport slave (
        input  host_vld, host_msg, ram_rdata, rsp_rdy,
        output host_rdy, ram_sel, ram_we, ram_re, ram_addr, ram_be, ram_wdata, rsp_vld, rsp_data
    );
endinterface

// File: rtl/tts_host_msg_dec.sv
// tts_host_msg_dec: decodes host messages into RCB RAM write/read strobes and read responses.
// Define TTS_HOST_RD_EN to build the read path (RWAIT/RESP); without it READ counts as illegal.
module tts_host_msg_dec #(
    parameter int RD_LAT = 2,
    parameter int ERR_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    tts_host_msg_dec_if.slave  bus,
    output logic [ERR_W-1:0]   err_cnt
);
`ifdef TTS_HOST_RD_EN
    typedef enum logic [1:0] {IDLE, DISP, RWAIT, RESP} state_t;
`else
    typedef enum logic {IDLE, DISP} state_t;
`endif
    state_t state_q, state_d;
    logic host_rdy_q, host_rdy_d, we_q, we_d, rd_q, rd_d, ill_q, ill_d;
    logic [3:0] sel_q, sel_d;
    logic [15:0] addr_q, addr_d;
    logic [23:0] be_q, be_d;
    logic [191:0] wdata_q, wdata_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [7:0] cmd;
    logic ram_ok, wr_ok, rd_ok;
    assign cmd = bus.host_msg[255:248];
    assign ram_ok = bus.host_msg[247:240] inside {8'd1, 8'd2, 8'd4, 8'd8};
    assign wr_ok = cmd == 8'h01 && ram_ok;
`ifdef TTS_HOST_RD_EN
    logic [63:0] hdr_q, hdr_d;
    logic [3:0] cnt_q, cnt_d;
    logic rsp_vld_q, rsp_vld_d;
    logic [255:0] rsp_data_q, rsp_data_d;
    assign rd_ok = cmd == 8'h02 && ram_ok;
    assign bus.rsp_vld = rsp_vld_q;
    assign bus.rsp_data = rsp_data_q;
`else
    assign rd_ok = 1'b0;
    assign bus.rsp_vld = 1'b0;
    assign bus.rsp_data = '0;
`endif
    assign bus.host_rdy = host_rdy_q;
    assign bus.ram_we = we_q;
    assign bus.ram_re = rd_q;
    assign bus.ram_sel = sel_q;
    assign bus.ram_addr = addr_q;
    assign bus.ram_be = be_q;
    assign bus.ram_wdata = wdata_q;
    assign err_cnt = err_q;
    // Strobes are decided at acceptance so they land in the DISP cycle itself.
    always_comb begin
        state_d = state_q;
        sel_d = sel_q;
        addr_d = addr_q;
        be_d = be_q;
        wdata_d = wdata_q;
        we_d = 1'b0;
        rd_d = 1'b0;
        ill_d = 1'b0;
        err_d = (ill_q && !(&err_q)) ? err_q + 1'b1 : err_q;
`ifdef TTS_HOST_RD_EN
        hdr_d = hdr_q;
        cnt_d = cnt_q;
        rsp_vld_d = rsp_vld_q;
        rsp_data_d = rsp_data_q;
`endif
        if (state_q == IDLE && bus.host_vld) begin
            state_d = DISP;
            sel_d = bus.host_msg[243:240];
            addr_d = bus.host_msg[239:224];
            be_d = bus.host_msg[215:192];
            wdata_d = bus.host_msg[191:0];
            we_d = wr_ok && |bus.host_msg[215:192];
            rd_d = rd_ok;
            ill_d = !(wr_ok || rd_ok);
`ifdef TTS_HOST_RD_EN
            hdr_d = bus.host_msg[255:192];
`endif
        end
`ifdef TTS_HOST_RD_EN
        if (state_q == DISP) begin
            state_d = rd_q ? RWAIT : IDLE;
            cnt_d = 4'(RD_LAT);
        end
        if (state_q == RWAIT) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == 4'd1) begin
                rsp_data_d = {hdr_q, bus.ram_rdata};
                rsp_vld_d = 1'b1;
                state_d = RESP;
            end
        end
        if (state_q == RESP && bus.rsp_rdy) begin
            rsp_vld_d = 1'b0;
            state_d = IDLE;
        end
`else
        if (state_q == DISP) state_d = IDLE;
`endif
        host_rdy_d = state_d == IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            host_rdy_q <= 1'b1;
            we_q <= 1'b0;
            rd_q <= 1'b0;
            ill_q <= 1'b0;
            sel_q <= '0;
            addr_q <= '0;
            be_q <= '0;
            wdata_q <= '0;
            err_q <= '0;
`ifdef TTS_HOST_RD_EN
            hdr_q <= '0;
            cnt_q <= '0;
            rsp_vld_q <= 1'b0;
            rsp_data_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            host_rdy_q <= host_rdy_d;
            we_q <= we_d;
            rd_q <= rd_d;
            ill_q <= ill_d;
            sel_q <= sel_d;
            addr_q <= addr_d;
            be_q <= be_d;
            wdata_q <= wdata_d;
            err_q <= err_d;
`ifdef TTS_HOST_RD_EN
            hdr_q <= hdr_d;
            cnt_q <= cnt_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
`endif
        end
    end
endmodule

// File: doc/tts_host_msg_dec.md
# tts_host_msg_dec

Host-message decoder for the strategy block configuration path. It accepts 256-bit host messages one at a time through a valid/ready handshake and checks the command and RAM-select fields. Legal writes go out as single-cycle, byte-enabled strobes to one of the four RCB RAMs (symbol, price, volume, order). Legal reads go out as read strobes, and the read data returns to the host as a response message. It sits between the host interface and the SRCB/PRCB/VRCB/ORCB RAMs.

## Interface
- RD_LAT, 2: RAM read latency in cycles, from `ram_re` to valid `ram_rdata`; legal range 1..15.
- ERR_W, 16: width of the illegal-message counter.

Ports:
- clk  in  1  block clock.
- reset  in  1  synchronous, active-high reset.
- host_vld  in  1  host message valid.
- host_rdy  out  1  decoder can accept a message.
- host_msg  in  256  host message fields:
  - cmd [255:248]
  - ram [247:240]
  - addr [239:224]
  - res [223:216]
  - byte_en [215:192]
  - data [191:0]
- ram_sel  out  4  one-hot RAM select: bit0 SRCB, bit1 PRCB, bit2 VRCB, bit3 ORCB.
- ram_we  out  1  write strobe, one cycle.
- ram_re  out  1  read strobe, one cycle.
- ram_addr  out  16  RAM word address.
- ram_be  out  24  byte enables; bit i covers wdata[8i+7:8i].
- ram_wdata  out  192  write data.
- ram_rdata  in  192  read data, muxed externally by `ram_sel`.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response accepted.
- rsp_data  out  256  response message: the header [255:192] echoed from the request, with `ram_rdata` in [191:0].
- err_cnt  out  ERR_W  count of illegal messages; saturates.

## Operation
- Command encodings:
  - 8'h01 = WRITE
  - 8'h02 = READ
  - any other value = illegal.
- The RAM field is legal only if it is exactly 8'd1, 8'd2, 8'd4 or 8'd8. `ram_sel` = ram[3:0].
- The `res` field is ignored.
- FSM states: IDLE, DISP, RWAIT, RESP.
- IDLE:
  - `host_rdy`=1.
  - On `host_vld`&&`host_rdy`, register `host_msg` and go to DISP.
- DISP (`host_rdy`=0):
  - Legal WRITE with byte_en≠0: assert `ram_we` for one cycle with `ram_sel`/`ram_addr`/`ram_be`/`ram_wdata` → IDLE.
  - Legal WRITE with byte_en=0: no strobe, not an error → IDLE.
  - Legal READ: assert `ram_re` for one cycle, load latency counter with RD_LAT → RWAIT.
  - Illegal command or RAM field: increment `err_cnt` (saturating at all-ones), no strobe → IDLE.
- RWAIT:
  - Decrement the counter each cycle.
  - When it reaches 0, capture `ram_rdata` into `rsp_data`[191:0] → RESP.
- RESP:
  - Hold `rsp_vld`=1 and `rsp_data` stable until `rsp_rdy`=1, then → IDLE.
- `ram_sel`/`ram_addr`/`ram_be`/`ram_wdata` are don't-care when no strobe is asserted, but must be held stable from `ram_re` through RWAIT.
- Reset values:
  - state = IDLE, `host_rdy`=1.
  - `ram_we`=0, `ram_re`=0, `ram_sel`=0, `ram_addr`=0, `ram_be`=0, `ram_wdata`=0.
  - `rsp_vld`=0, `rsp_data`=0, `err_cnt`=0.
- Reset mid-operation: any in-flight read or pending response is discarded. No strobe is issued on the cycle after reset.

## Timing
- All outputs are registered.
- Write: message accepted at edge N; `ram_we` is high during cycle N+1. `host_rdy` returns high in cycle N+2, so sustained throughput is one message per 2 cycles.
- Read:
  - `ram_re` is high during cycle N+1.
  - `ram_rdata` is sampled at the edge ending cycle N+1+RD_LAT.
  - `rsp_vld` rises in cycle N+2+RD_LAT.
  - With `rsp_rdy` held high, `host_rdy` returns in cycle N+3+RD_LAT.
- `rsp_vld` never drops without `rsp_rdy`. A new host message is never accepted while a response is pending.
- `host_vld` held high while `host_rdy`=0 has no effect; that message is accepted on the next IDLE cycle.

## Configuration
- TTS_HOST_RD_EN defined: the read path (RWAIT, RESP, counter, response register) is present as described above.
- TTS_HOST_RD_EN undefined:
  - READ is treated as illegal and increments `err_cnt`.
  - `ram_re`, `rsp_vld` and `rsp_data` are tied to 0; `ram_rdata` and `rsp_rdy` are unused.
  - The FSM has IDLE and DISP only.

## Test plan
- WRITE: cmd=01, ram=04, addr=16'h0123, byte_en=24'h00000F, data=…DEADBEEF → one-cycle `ram_we`, `ram_sel`=4'b0100, `ram_addr`=16'h0123, `ram_be`=24'h00000F, `ram_wdata`[31:0]=32'hDEADBEEF, `err_cnt` unchanged.
- READ with RD_LAT=2: cmd=02, ram=08, addr=16'h0010, `ram_rdata`=192'hA5 two cycles after `ram_re` → `rsp_vld` in cycle N+4, `rsp_data`[255:192] equal to the request header, `rsp_data`[191:0]=192'hA5.
- Response backpressure: `rsp_rdy`=0 for 5 cycles while a second host message is pending → `rsp_vld`/`rsp_data` stable, `host_rdy`=0; second message accepted only after the handshake.
- Illegal messages, in order: ram=03, then cmd=07, then WRITE with byte_en=0 → `err_cnt`=2, no `ram_we`/`ram_re`. With ERR_W=2 and 5 illegal messages, `err_cnt` holds at 3.
- Reset asserted during RWAIT → next cycle state IDLE, `rsp_vld`=0, `err_cnt`=0, no response ever emitted.
- Build without TTS_HOST_RD_EN, send READ → `err_cnt`+1, `ram_re`=0, `rsp_vld`=0, `host_rdy` back high in cycle N+2.
